parity_rx: RTL and testbench



---
 rtl/parity_pkg.sv | 25 ++
 rtl/parity.sv | 14 +
 rtl/parity_rx.sv | 173 +++++++++++++++++
 tb/tb_parity_rx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// parity_pkg: shared definitions for the parity generator / receiver pair.
//   rx_state_t  - receiver FSM states (IDLE, DATA, PARITY, STOP)
//   PAR_EVEN    - required XOR of data bits plus parity bit for a good frame
//   ERRCNT_W    - width of the optional error-frame counter
//   even_par16  - even-parity bit over up to 16 data bits (zero-extend narrower words)
package parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // Even parity: data bits XOR parity bit must come out as zero.
    localparam logic PAR_EVEN = 1'b0;

    localparam int ERRCNT_W = 8;

    // Even-parity bit; zero padding does not change the result.
    function automatic logic even_par16(input logic [15:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/parity.sv
// parity: combinational even-parity generator over a 4-bit word.
// Ports:
//   data  in  4  word to protect
//   par   out 1  parity bit that makes the total number of ones even
module parity
    import parity_pkg::*;
(
    input  logic [3:0] data,
    output logic       par
);

    assign par = even_par16({12'h000, data});

endmodule

// File: rtl/parity_rx.sv
// parity_rx: serial parity-frame receiver.
// Frame on din (sampled only when bit_en=1): start(0), DATA_W data bits
// LSB-first, even-parity bit, stop(1). The recovered word and the parity /
// framing error flags are registered together with a one-cycle valid pulse
// and hold until the next frame completes.
// Ports:
//   clk        in   1       system clock, rising edge
//   rst        in   1       synchronous active-high reset
//   din        in   1       serial line, idles high
//   bit_en     in   1       bit strobe
//   data_out   out  DATA_W  last received word
//   valid      out  1       frame-complete pulse
//   par_err    out  1       parity mismatch (qualified by valid)
//   frame_err  out  1       stop bit sampled low (qualified by valid)
//   busy       out  1       frame in progress
//   err_cnt    out  8       saturating error-frame count (PARITY_RX_ERRCNT_EN only)
// Build option: define PARITY_RX_ERRCNT_EN to add the error counter and err_cnt port.
module parity_rx
    import parity_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              par_err,
    output logic              frame_err,
    output logic              busy
`ifdef PARITY_RX_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_cnt
`endif
);

    localparam int              CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    rx_state_t         state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [DATA_W-1:0] shift_r, shift_nxt_s;
    logic              rx_par_r, rx_par_nxt_s;
    logic              done_s;
    logic              calc_par_s;

    logic [DATA_W-1:0] data_out_r;
    logic              valid_r;
    logic              par_err_r;
    logic              frame_err_r;
    logic              busy_r;

    // The 4-bit case reuses the standalone generator; other widths reduce inline.
    generate
        if (DATA_W == 4) begin : g_par_inst
            parity u_parity (
                .data (shift_r),
                .par  (calc_par_s)
            );
        end else begin : g_par_inline
            assign calc_par_s = even_par16(16'(shift_r));
        end
    endgenerate

    // Next-state and datapath update; nothing moves on cycles without a strobe.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        shift_nxt_s  = shift_r;
        rx_par_nxt_s = rx_par_r;
        done_s       = 1'b0;
        if (bit_en) begin
            case (state_r)
                ST_IDLE: begin
                    if (!din) begin
                        state_nxt_s = ST_DATA;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_nxt_s[cnt_r] = din;
                    cnt_nxt_s          = cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = ST_PARITY;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    rx_par_nxt_s = din;
                    state_nxt_s  = ST_STOP;
                end
                ST_STOP: begin
                    // No wait for the line to go high: the next strobe may be a new start bit.
                    done_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM and datapath registers; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            shift_r  <= {DATA_W{1'b0}};
            rx_par_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            shift_r  <= shift_nxt_s;
            rx_par_r <= rx_par_nxt_s;
        end
    end

    // Registered outputs: word and flags load on the stop-bit strobe and then hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r  <= {DATA_W{1'b0}};
            valid_r     <= 1'b0;
            par_err_r   <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            valid_r <= done_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            if (done_s) begin
                data_out_r  <= shift_r;
                par_err_r   <= ((calc_par_s ^ rx_par_r) != PAR_EVEN);
                frame_err_r <= ~din;
            end else begin
                data_out_r  <= data_out_r;
                par_err_r   <= par_err_r;
                frame_err_r <= frame_err_r;
            end
        end
    end

    assign data_out  = data_out_r;
    assign valid     = valid_r;
    assign par_err   = par_err_r;
    assign frame_err = frame_err_r;
    assign busy      = busy_r;

`ifdef PARITY_RX_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_r;

    // Count error frames during their valid cycle, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= {ERRCNT_W{1'b0}};
        end else if (valid_r && (par_err_r || frame_err_r) &&
                     (err_cnt_r != {ERRCNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + ERRCNT_W'(32'd1);
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_parity_rx.sv
// tb_parity_rx: directed bench for parity_rx (DATA_W=4) with a frame-level
// reference model compared every cycle, plus literal expectations per frame.
module tb_parity_rx;
    import parity_pkg::*;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       din    = 1'b1;
    logic       bit_en = 1'b0;
    logic [3:0] data_out;
    logic       valid, par_err, frame_err, busy;
`ifdef PARITY_RX_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    parity_rx #(.DATA_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .bit_en    (bit_en),
        .data_out  (data_out),
        .valid     (valid),
        .par_err   (par_err),
        .frame_err (frame_err),
        .busy      (busy)
`ifdef PARITY_RX_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: counts strobes into the frame, collects bits, judges the frame.
    int         m_n      = 0;
    logic [3:0] m_word   = 4'd0;
    logic       m_pbit   = 1'b0;
    logic [3:0] m_data   = 4'd0;
    logic       m_valid  = 1'b0;
    logic       m_pe     = 1'b0;
    logic       m_fe     = 1'b0;
    logic       m_busy   = 1'b0;
    int         m_errcnt = 0;
    bit         armed    = 1'b0;

    always @(posedge clk) begin
        int ones;
        armed = 1'b1;
        if (rst) begin
            m_n = 0; m_word = 4'd0; m_data = 4'd0;
            m_valid = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_errcnt = 0;
        end else begin
            if (m_valid && (m_pe || m_fe) && m_errcnt < 255) m_errcnt++;
            m_valid = 1'b0;
            if (bit_en) begin
                if (m_n == 0) begin
                    if (din == 1'b0) m_n = 1;
                end else if (m_n <= 4) begin
                    m_word[m_n-1] = din;
                    m_n++;
                end else if (m_n == 5) begin
                    m_pbit = din;
                    m_n++;
                end else begin
                    ones = 0;
                    for (int i = 0; i < 4; i++) ones += int'(m_word[i]);
                    m_data  = m_word;
                    m_pe    = ((ones + int'(m_pbit)) % 2) != 0;
                    m_fe    = (din == 1'b0);
                    m_valid = 1'b1;
                    m_n     = 0;
                end
            end
        end
        m_busy = (m_n != 0);
    end

    // Every-cycle comparison against the model, and capture of each valid frame.
    logic [3:0] cap_data [16];
    logic       cap_pe   [16];
    logic       cap_fe   [16];
    int         vcount = 0;

    always @(negedge clk) begin
        if (armed) begin
            chk("valid", valid, m_valid);
            chk("busy", busy, m_busy);
            chk("data_out", data_out, m_data);
            chk("par_err", par_err, m_pe);
            chk("frame_err", frame_err, m_fe);
`ifdef PARITY_RX_ERRCNT_EN
            chk("err_cnt", err_cnt, m_errcnt);
`endif
            if (valid === 1'b1 && vcount < 16) begin
                cap_data[vcount] = data_out;
                cap_pe[vcount]   = par_err;
                cap_fe[vcount]   = frame_err;
                vcount++;
            end
        end
    end

    function automatic logic [6:0] frame(input logic [3:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    task automatic send(input logic [6:0] fr, input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            din    = fr[i];
            bit_en = 1'b1;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                din    = 1'b1;
                bit_en = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din    = 1'b1;
            bit_en = 1'b0;
        end
    endtask

    task automatic chk_frame(input string name, input int idx,
                             input logic [3:0] d, input logic pe, input logic fe);
        chk({name, "_data"}, cap_data[idx], d);
        chk({name, "_pe"}, cap_pe[idx], pe);
        chk({name, "_fe"}, cap_fe[idx], fe);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_data", data_out, 4'd0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_flags", {par_err, frame_err}, 2'b00);
        rst = 1'b0;

        // Idle line with strobes every cycle.
        repeat (20) begin
            @(negedge clk);
            din = 1'b1; bit_en = 1'b1;
        end
        idle(2);
        chk("idle_vcount", vcount, 0);
        chk("idle_busy", busy, 1'b0);

        // Good frame 1011 (bits 0,1,1,0,1,1,1).
        base = vcount;
        send(frame(4'b1011, 1'b1, 1'b1), 0, 6, 0);
        idle(3);
        chk("good_count", vcount, base + 1);
        chk_frame("good", base, 4'b1011, 1'b0, 1'b0);

        // Parity error: 0110 has even ones, parity 1 sent.
        base = vcount;
        send(frame(4'b0110, 1'b1, 1'b1), 0, 6, 0);
        idle(3);
        chk("perr_count", vcount, base + 1);
        chk_frame("perr", base, 4'b0110, 1'b1, 1'b0);
`ifdef PARITY_RX_ERRCNT_EN
        chk("perr_errcnt", err_cnt, 8'd1);
`endif

        // Framing error followed immediately by a good frame 1100.
        base = vcount;
        send(frame(4'b0001, 1'b1, 1'b0), 0, 6, 0);
        send(frame(4'b1100, 1'b0, 1'b1), 0, 6, 0);
        idle(3);
        chk("b2b_count", vcount, base + 2);
        chk_frame("ferr", base, 4'b0001, 1'b0, 1'b1);
        chk_frame("b2b", base + 1, 4'b1100, 1'b0, 1'b0);
`ifdef PARITY_RX_ERRCNT_EN
        chk("ferr_errcnt", err_cnt, 8'd2);
`endif

        // Sparse strobe: one bit every third cycle.
        base = vcount;
        send(frame(4'b1111, 1'b0, 1'b1), 0, 6, 2);
        idle(3);
        chk("sparse_count", vcount, base + 1);
        chk_frame("sparse", base, 4'b1111, 1'b0, 1'b0);

        // Reset after two data bits abandons the frame.
        base = vcount;
        send(frame(4'b1010, 1'b0, 1'b1), 0, 2, 0);
        @(negedge clk);
        rst = 1'b1; bit_en = 1'b0; din = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid_busy", busy, 1'b0);
        idle(3);
        chk("rstmid_count", vcount, base);
        send(frame(4'b0101, 1'b0, 1'b1), 0, 6, 0);
        idle(3);
        chk("after_rst_count", vcount, base + 1);
        chk_frame("after_rst", base, 4'b0101, 1'b0, 1'b0);
`ifdef PARITY_RX_ERRCNT_EN
        chk("after_rst_errcnt", err_cnt, 8'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
